// File: rtl/sw_pkg.sv
// Shared constants and helpers for the switch debounce bank.
//  SW_SCAN_1MS_50M   : scan period giving one tick per 1 ms at 50 MHz
//  SW_STABLE_DEFAULT : default number of agreeing scan ticks needed to flip a bit
//  SW_WIDTH_DEFAULT  : default number of switch channels
//  sw_clog2()        : ceiling log2, used for counter widths
package sw_pkg;

   localparam int unsigned SW_SCAN_1MS_50M   = 49999;
   localparam int unsigned SW_STABLE_DEFAULT = 3;
   localparam int unsigned SW_WIDTH_DEFAULT  = 8;

   // Smallest r with 2**r >= v
   function automatic int unsigned sw_clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'(1) << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/switch_debounce_chan.sv
// One debounce channel: stability counter, debounced output bit and
// optional one-cycle rise/fall strobes.
//  sys_clk   in   system clock
//  sys_rst   in   asynchronous active-low reset
//  tick      in   scan tick (one clock wide)
//  sync_bit  in   synchronised switch level
//  out_bit   out  debounced level (registered)
//  rise      out  strobe, out_bit went 0->1 (SW_EDGE_EN only, else 0)
//  fall      out  strobe, out_bit went 1->0 (SW_EDGE_EN only, else 0)
// Build option: `define SW_EDGE_EN enables the rise/fall strobe registers.
module switch_debounce_chan
   import sw_pkg::*;
#(
   parameter int unsigned STABLE_SAMPLES = SW_STABLE_DEFAULT
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic tick,
   input  logic sync_bit,
   output logic out_bit,
   output logic rise,
   output logic fall
);

   localparam int unsigned CNT_W = sw_clog2(STABLE_SAMPLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

   logic [CNT_W-1:0] stab_cnt;

   // Count consecutive disagreeing ticks; flip the output on the last one
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         stab_cnt <= '0;
         out_bit  <= 1'b0;
      end else if (tick) begin
         if (sync_bit == out_bit) begin
            stab_cnt <= '0;
         end else if (stab_cnt == CNT_LAST) begin
            out_bit  <= sync_bit;
            stab_cnt <= '0;
         end else begin
            stab_cnt <= stab_cnt + CNT_W'(1);
         end
      end
   end

`ifdef SW_EDGE_EN
   logic flip_c;
   assign flip_c = tick && (sync_bit != out_bit) && (stab_cnt == CNT_LAST);

   // Strobes coincide with the cycle out_bit shows its new value
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= flip_c &  sync_bit;
         fall <= flip_c & ~sync_bit;
      end
   end
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debounce_bank.sv
// Bank of WIDTH independently debounced switch channels sampled once per
// scan period.
//  sys_clk        in   system clock (50 MHz)
//  sys_rst        in   asynchronous active-low reset
//  scan_en        in   1 = scan counter runs, 0 = counter holds (no ticks)
//  switch_input   in   raw asynchronous switch pins [WIDTH]
//  switch_output  out  debounced switch state [WIDTH]
//  sw_rise        out  one-cycle 0->1 strobes [WIDTH] (SW_EDGE_EN only)
//  sw_fall        out  one-cycle 1->0 strobes [WIDTH] (SW_EDGE_EN only)
//  sample_tick    out  one-cycle strobe on every scan tick
// Build option: `define SW_EDGE_EN enables sw_rise/sw_fall; otherwise they are 0.
module switch_debounce_bank
   import sw_pkg::*;
#(
   parameter int unsigned WIDTH          = SW_WIDTH_DEFAULT,
   parameter int unsigned SCAN_PERIOD    = SW_SCAN_1MS_50M,
   parameter int unsigned STABLE_SAMPLES = SW_STABLE_DEFAULT
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             scan_en,
   input  logic [WIDTH-1:0] switch_input,
   output logic [WIDTH-1:0] switch_output,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sample_tick
);

   localparam int unsigned SCAN_W = sw_clog2(SCAN_PERIOD + 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD);

   logic [WIDTH-1:0]  sync_meta;
   logic [WIDTH-1:0]  sync_q;
   logic [SCAN_W-1:0] scan_cnt;
   logic              tick_c;

   // Two-flop synchroniser for the asynchronous pins
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         sync_meta <= '0;
         sync_q    <= '0;
      end else begin
         sync_meta <= switch_input;
         sync_q    <= sync_meta;
      end
   end

   assign tick_c = (scan_cnt == SCAN_LAST) && scan_en;

   // Scan counter holds its value while scan_en is low
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         scan_cnt    <= '0;
         sample_tick <= 1'b0;
      end else begin
         sample_tick <= tick_c;
         if (scan_en) begin
            scan_cnt <= tick_c ? '0 : scan_cnt + SCAN_W'(1);
         end
      end
   end

   // One debounce channel per switch
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chan
      switch_debounce_chan #(
         .STABLE_SAMPLES (STABLE_SAMPLES)
      ) u_chan (
         .sys_clk  (sys_clk),
         .sys_rst  (sys_rst),
         .tick     (tick_c),
         .sync_bit (sync_q[i]),
         .out_bit  (switch_output[i]),
         .rise     (sw_rise[i]),
         .fall     (sw_fall[i])
      );
   end

endmodule
